cv_memmap: RTL and testbench
============================

# cv_memmap

Z80 memory/IO address decoder and cartridge bank controller for the ColecoVision core. Sits between the CPU bus and the external memories: BIOS ROM, 8K base RAM, 32K Super-Game-Module (SGM) upper RAM and cartridge store. Steers address, chip-select and write-enable to each memory and multiplexes read data back to the CPU. Also holds the SGM enable registers and the MegaCart bank register.

## Interface
Parameters: none.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en_10m7_i  in  1  CPU clock enable; registers update only when high
- sg1000_i  in  1  SG-1000 memory map select
- dahjeeA_i  in  1  SG-1000 extra RAM at 2000-3FFF
- cpu_a_i  in  16  CPU address
- cpu_d_i  in  8  CPU write data
- cpu_mreq_n_i, cpu_iorq_n_i, cpu_rd_n_i, cpu_wr_n_i, cpu_rfsh_n_i  in  1 each  Z80 strobes, active-low
- cpu_d_o  out  8  read data to CPU
- bios_rom_a_o  out  13 / bios_rom_d_i  in  8  BIOS ROM
- cpu_ram_a_o  out  15, cpu_ram_ce_n_o  out  1, cpu_ram_we_n_o  out  1, cpu_ram_d_i  in  8, cpu_ram_d_o  out  8  base RAM
- cpu_upper_ram_a_o  out  15, cpu_upper_ram_ce_n_o  out  1, cpu_upper_ram_we_n_o  out  1, cpu_upper_ram_d_i  in  8, cpu_upper_ram_d_o  out  8  SGM RAM (port A of sdpramv)
- cart_pages_i  in  6  index of last 16K cartridge page (image size−1)[19:14]
- cart_a_o  out  20 / cart_d_i  in  8 / cart_rd_o  out  1  cartridge store

## Operation
- mem = ~mreq_n & rfsh_n; io_wr = ~iorq_n & ~wr_n. Exactly one memory select is active per mem cycle; no select when mem=0.
- cpu_ram_d_o and cpu_upper_ram_d_o = cpu_d_i. we_n = wr_n | ~sel; ce_n = ~sel.
- Registers (reset values): sgm_upper_en=0, bios_off=0, bank=0.
  - io_wr to port A[7:0]=0x53: sgm_upper_en <= D[0].
  - io_wr to port 0x7F: bios_off <= ~D[1].
  - Any mem access (read or write) in CV mode to FFC0-FFFF, while cart_pages_i ≥ 2: bank <= A[5:0] & cart_pages_i.
- CV map (sg1000_i=0):
  - 0000-1FFF: bios_off ? upper RAM, addr A[14:0] : BIOS, addr A[12:0].
  - 2000-5FFF: sgm_upper_en ? upper RAM, addr A[14:0] : unmapped.
  - 6000-7FFF: base RAM, addr {2'b0, A[12:0]}.
  - 8000-FFFF: cartridge. If cart_pages_i ≤ 1: cart_a = {5'b0, A[14:0]}. Else 8000-BFFF → {cart_pages_i, A[13:0]} (fixed last page); C000-FFFF → {bank, A[13:0]}.
- SG-1000 map (sg1000_i=1): 0000-BFFF cartridge {4'b0, A}, except 2000-3FFF → upper RAM A[12:0] when dahjeeA_i=1. C000-FFFF base RAM A[12:0] (mirrored). SGM/bank registers ignored.
- cart_rd_o = cart select & ~rd_n.
- cpu_d_o: data of the selected memory; 0xFF when unmapped or no mem cycle.

## Timing
- Decode, selects, addresses and cpu_d_o are combinational from inputs and registers.
- Register writes occur at the clk_sys rising edge where clk_en_10m7_i=1 and the qualifying strobe condition holds. Strobes held across several enables rewrite the same value; this is harmless.
- Memories have 1-cycle synchronous read. Each CPU cycle spans ≥2 clk_sys cycles, so data is valid before sampling.
- Reset has priority over any simultaneous register write. A reset during a bus cycle returns the map to BIOS-visible, SGM off, bank 0 on the next edge.
- bank wraps via the & cart_pages_i mask; out-of-range bank numbers alias.

## Test plan
- After reset, read 0x0000 with bios_rom_d_i=0x31 → bios_rom_a_o=0, cpu_d_o=0x31. Read 0x2000 → cpu_d_o=0xFF, no ce_n low.
- OUT 0x53←0x01, OUT 0x7F←0x00 → write 0x0100 asserts cpu_upper_ram_we_n_o=0 with addr 0x0100. Read 0x4000 selects upper RAM addr 0x4000.
- Write 0x6005←0xAA → cpu_ram_a_o=0x0005, we_n=0, d_o=0xAA. BIOS/cart selects stay inactive.
- cart_pages_i=7, read 0xFFC3 then read 0xC010 → cart_a_o=0x0C010. Read 0x8000 → cart_a_o=0x1C000. Reset → read 0xC010 gives 0x00010.
- cart_pages_i=1, read 0xFFC5 → bank unchanged; read 0xC000 → cart_a_o=0x04000.
- sg1000_i=1, read 0x1234 → cart_a_o=0x01234. Write 0xE001 → cpu_ram_a_o=0x0001. With dahjeeA_i=1, 0x2001 → upper RAM addr 0x0001.

Source files
------------

// File: rtl/cv_memmap_if.sv
// cv_memmap_if -- Z80 CPU-side bus bundle for the ColecoVision memory map.
//   cpu_a_i        16  CPU address
//   cpu_d_i         8  CPU write data
//   cpu_mreq_n_i, cpu_iorq_n_i, cpu_rd_n_i, cpu_wr_n_i, cpu_rfsh_n_i
//                      Z80 strobes, active-low
//   cpu_d_o         8  read data returned to the CPU
// master: the CPU side (drives address/data/strobes, receives read data).
// slave:  the decoder side (cv_memmap).
interface cv_memmap_if;
    logic [15:0] cpu_a_i;
    logic [7:0]  cpu_d_i;
    logic        cpu_mreq_n_i;
    logic        cpu_iorq_n_i;
    logic        cpu_rd_n_i;
    logic        cpu_wr_n_i;
    logic        cpu_rfsh_n_i;
    logic [7:0]  cpu_d_o;

    modport master (
        output cpu_a_i, cpu_d_i, cpu_mreq_n_i, cpu_iorq_n_i,
               cpu_rd_n_i, cpu_wr_n_i, cpu_rfsh_n_i,
        input  cpu_d_o
    );

    modport slave (
        input  cpu_a_i, cpu_d_i, cpu_mreq_n_i, cpu_iorq_n_i,
               cpu_rd_n_i, cpu_wr_n_i, cpu_rfsh_n_i,
        output cpu_d_o
    );
endinterface

// File: rtl/cv_memmap.sv
// cv_memmap -- Z80 memory/IO address decoder and cartridge bank controller
// for the ColecoVision core.  Steers address, chip-select and write-enable to
// BIOS ROM, 8K base RAM, 32K SGM upper RAM and the cartridge store, and
// multiplexes read data back to the CPU.  Holds the SGM enable registers and
// the MegaCart bank register.
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   clk_en_10m7_i           CPU clock enable; registers update only when high
//   sg1000_i, dahjeeA_i     SG-1000 map select, SG-1000 extra RAM at 2000-3FFF
//   bus                     CPU bus (cv_memmap_if.slave)
//   bios_rom_*              BIOS ROM address / data
//   cpu_ram_*               base RAM address, ce_n, we_n, data in/out
//   cpu_upper_ram_*         SGM upper RAM address, ce_n, we_n, data in/out
//   cart_pages_i            index of last 16K cartridge page
//   cart_a_o, cart_d_i, cart_rd_o   cartridge store
module cv_memmap (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        clk_en_10m7_i,
    input  logic        sg1000_i,
    input  logic        dahjeeA_i,
    cv_memmap_if.slave  bus,
    output logic [12:0] bios_rom_a_o,
    input  logic [7:0]  bios_rom_d_i,
    output logic [14:0] cpu_ram_a_o,
    output logic        cpu_ram_ce_n_o,
    output logic        cpu_ram_we_n_o,
    input  logic [7:0]  cpu_ram_d_i,
    output logic [7:0]  cpu_ram_d_o,
    output logic [14:0] cpu_upper_ram_a_o,
    output logic        cpu_upper_ram_ce_n_o,
    output logic        cpu_upper_ram_we_n_o,
    input  logic [7:0]  cpu_upper_ram_d_i,
    output logic [7:0]  cpu_upper_ram_d_o,
    input  logic [5:0]  cart_pages_i,
    output logic [19:0] cart_a_o,
    input  logic [7:0]  cart_d_i,
    output logic        cart_rd_o
);

    logic        mem;
    logic        io_wr;
    logic        sel_bios;
    logic        sel_ram;
    logic        sel_upper;
    logic        sel_cart;
    logic [15:0] a;

    logic       sgm_upper_en_q, sgm_upper_en_d;
    logic       bios_off_q, bios_off_d;
    logic [5:0] bank_q, bank_d;

    assign a     = bus.cpu_a_i;
    assign mem   = ~bus.cpu_mreq_n_i & bus.cpu_rfsh_n_i;
    assign io_wr = ~bus.cpu_iorq_n_i & ~bus.cpu_wr_n_i;

    // Register next-state
    always_comb begin
        sgm_upper_en_d = sgm_upper_en_q;
        bios_off_d     = bios_off_q;
        bank_d         = bank_q;
        if (clk_en_10m7_i) begin
            if (io_wr && a[7:0] == 8'h53) sgm_upper_en_d = bus.cpu_d_i[0];
            if (io_wr && a[7:0] == 8'h7F) bios_off_d     = ~bus.cpu_d_i[1];
            // MegaCart: any access to FFC0-FFFF latches a bank, masked so
            // out-of-range numbers alias into the image.
            if (mem && !sg1000_i && a[15:6] == 10'h3FF && cart_pages_i >= 6'd2)
                bank_d = a[5:0] & cart_pages_i;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sgm_upper_en_q <= 1'b0;
            bios_off_q     <= 1'b0;
            bank_q         <= '0;
        end else begin
            sgm_upper_en_q <= sgm_upper_en_d;
            bios_off_q     <= bios_off_d;
            bank_q         <= bank_d;
        end
    end

    // Address decode and memory address steering
    always_comb begin
        sel_bios          = 1'b0;
        sel_ram           = 1'b0;
        sel_upper         = 1'b0;
        sel_cart          = 1'b0;
        bios_rom_a_o      = a[12:0];
        cpu_ram_a_o       = {2'b00, a[12:0]};
        cpu_upper_ram_a_o = a[14:0];
        cart_a_o          = {4'b0000, a};
        if (mem) begin
            if (sg1000_i) begin
                if (a[15:14] == 2'b11) begin
                    sel_ram = 1'b1;
                end else if (dahjeeA_i && a[15:13] == 3'b001) begin
                    sel_upper         = 1'b1;
                    cpu_upper_ram_a_o = {2'b00, a[12:0]};
                end else begin
                    sel_cart = 1'b1;
                end
            end else begin
                if (a[15]) begin
                    sel_cart = 1'b1;
                    if (cart_pages_i <= 6'd1)
                        cart_a_o = {5'b00000, a[14:0]};
                    else if (!a[14])
                        cart_a_o = {cart_pages_i, a[13:0]};
                    else
                        cart_a_o = {bank_q, a[13:0]};
                end else if (a[14:13] == 2'b11) begin
                    sel_ram = 1'b1;
                end else if (a[14:13] == 2'b00) begin
                    if (bios_off_q) sel_upper = 1'b1;
                    else            sel_bios  = 1'b1;
                end else begin
                    sel_upper = sgm_upper_en_q;
                end
            end
        end
    end

    assign cpu_ram_ce_n_o       = ~sel_ram;
    assign cpu_ram_we_n_o       = bus.cpu_wr_n_i | ~sel_ram;
    assign cpu_ram_d_o          = bus.cpu_d_i;
    assign cpu_upper_ram_ce_n_o = ~sel_upper;
    assign cpu_upper_ram_we_n_o = bus.cpu_wr_n_i | ~sel_upper;
    assign cpu_upper_ram_d_o    = bus.cpu_d_i;
    assign cart_rd_o            = sel_cart & ~bus.cpu_rd_n_i;

    // Read data mux; unmapped or idle reads float high like an open bus
    always_comb begin
        bus.cpu_d_o = 8'hFF;
        if (sel_bios)       bus.cpu_d_o = bios_rom_d_i;
        else if (sel_ram)   bus.cpu_d_o = cpu_ram_d_i;
        else if (sel_upper) bus.cpu_d_o = cpu_upper_ram_d_i;
        else if (sel_cart)  bus.cpu_d_o = cart_d_i;
    end

endmodule

// File: tb/tb_cv_memmap.sv
// tb_cv_memmap -- scoreboard bench for cv_memmap.  Expected output values are
// queued alongside each bus operation and drained while the cycle is active.
module tb_cv_memmap;

    localparam int S_DO      = 0;
    localparam int S_BIOS_A  = 1;
    localparam int S_RAM_A   = 2;
    localparam int S_RAM_CE  = 3;
    localparam int S_RAM_WE  = 4;
    localparam int S_RAM_DO  = 5;
    localparam int S_UP_A    = 6;
    localparam int S_UP_CE   = 7;
    localparam int S_UP_WE   = 8;
    localparam int S_CART_A  = 9;
    localparam int S_CART_RD = 10;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_IO   = 2;
    localparam int K_RFSH = 3;
    localparam int K_IDLE = 4;

    typedef struct {
        string       tag;
        int          sig;
        logic [19:0] val;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        clk_en_10m7_i;
    logic        sg1000_i;
    logic        dahjeeA_i;
    logic [12:0] bios_rom_a_o;
    logic [7:0]  bios_rom_d_i;
    logic [14:0] cpu_ram_a_o;
    logic        cpu_ram_ce_n_o;
    logic        cpu_ram_we_n_o;
    logic [7:0]  cpu_ram_d_i;
    logic [7:0]  cpu_ram_d_o;
    logic [14:0] cpu_upper_ram_a_o;
    logic        cpu_upper_ram_ce_n_o;
    logic        cpu_upper_ram_we_n_o;
    logic [7:0]  cpu_upper_ram_d_i;
    logic [7:0]  cpu_upper_ram_d_o;
    logic [5:0]  cart_pages_i;
    logic [19:0] cart_a_o;
    logic [7:0]  cart_d_i;
    logic        cart_rd_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    cv_memmap_if bus ();

    cv_memmap dut (
        .clk_sys              (clk_sys),
        .reset                (reset),
        .clk_en_10m7_i        (clk_en_10m7_i),
        .sg1000_i             (sg1000_i),
        .dahjeeA_i            (dahjeeA_i),
        .bus                  (bus.slave),
        .bios_rom_a_o         (bios_rom_a_o),
        .bios_rom_d_i         (bios_rom_d_i),
        .cpu_ram_a_o          (cpu_ram_a_o),
        .cpu_ram_ce_n_o       (cpu_ram_ce_n_o),
        .cpu_ram_we_n_o       (cpu_ram_we_n_o),
        .cpu_ram_d_i          (cpu_ram_d_i),
        .cpu_ram_d_o          (cpu_ram_d_o),
        .cpu_upper_ram_a_o    (cpu_upper_ram_a_o),
        .cpu_upper_ram_ce_n_o (cpu_upper_ram_ce_n_o),
        .cpu_upper_ram_we_n_o (cpu_upper_ram_we_n_o),
        .cpu_upper_ram_d_i    (cpu_upper_ram_d_i),
        .cpu_upper_ram_d_o    (cpu_upper_ram_d_o),
        .cart_pages_i         (cart_pages_i),
        .cart_a_o             (cart_a_o),
        .cart_d_i             (cart_d_i),
        .cart_rd_o            (cart_rd_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] obs(input int s);
        case (s)
            S_DO:      return {12'h0, bus.cpu_d_o};
            S_BIOS_A:  return {7'h0, bios_rom_a_o};
            S_RAM_A:   return {5'h0, cpu_ram_a_o};
            S_RAM_CE:  return {19'h0, cpu_ram_ce_n_o};
            S_RAM_WE:  return {19'h0, cpu_ram_we_n_o};
            S_RAM_DO:  return {12'h0, cpu_ram_d_o};
            S_UP_A:    return {5'h0, cpu_upper_ram_a_o};
            S_UP_CE:   return {19'h0, cpu_upper_ram_ce_n_o};
            S_UP_WE:   return {19'h0, cpu_upper_ram_we_n_o};
            S_CART_A:  return cart_a_o;
            S_CART_RD: return {19'h0, cart_rd_o};
            default:   return 20'hFFFFF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [19:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic set_idle();
        bus.cpu_mreq_n_i = 1'b1;
        bus.cpu_iorq_n_i = 1'b1;
        bus.cpu_rd_n_i   = 1'b1;
        bus.cpu_wr_n_i   = 1'b1;
        bus.cpu_rfsh_n_i = 1'b1;
    endtask

    // Drive one bus operation across a clock edge; queued expectations are
    // compared mid-cycle, before the edge that may update registers.
    task automatic bus_op(input int kind, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        set_idle();
        bus.cpu_a_i = a;
        bus.cpu_d_i = d;
        case (kind)
            K_RD:   begin bus.cpu_mreq_n_i = 1'b0; bus.cpu_rd_n_i = 1'b0; end
            K_WR:   begin bus.cpu_mreq_n_i = 1'b0; bus.cpu_wr_n_i = 1'b0; end
            K_IO:   begin bus.cpu_iorq_n_i = 1'b0; bus.cpu_wr_n_i = 1'b0; end
            K_RFSH: begin bus.cpu_mreq_n_i = 1'b0; bus.cpu_rfsh_n_i = 1'b0; end
            default: ;
        endcase
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.sig), e.val);
        end
        @(posedge clk_sys);
        #1;
        set_idle();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        clk_en_10m7_i     = 1'b1;
        sg1000_i          = 1'b0;
        dahjeeA_i         = 1'b0;
        bios_rom_d_i      = 8'h31;
        cpu_ram_d_i       = 8'h5A;
        cpu_upper_ram_d_i = 8'hC3;
        cart_d_i          = 8'h7E;
        cart_pages_i      = 6'd7;
        bus.cpu_a_i       = '0;
        bus.cpu_d_i       = '0;
        set_idle();
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;

        // Idle bus: no selects, open-bus data
        expect_val("idle_do", S_DO, 20'hFF);
        expect_val("idle_ram_ce", S_RAM_CE, 20'h1);
        expect_val("idle_up_ce", S_UP_CE, 20'h1);
        expect_val("idle_cart_rd", S_CART_RD, 20'h0);
        bus_op(K_IDLE, 16'h8000, 8'h00);

        // Refresh cycle is not a memory access
        expect_val("rfsh_do", S_DO, 20'hFF);
        expect_val("rfsh_cart_rd", S_CART_RD, 20'h0);
        bus_op(K_RFSH, 16'h8000, 8'h00);

        // BIOS visible after reset
        expect_val("bios_a", S_BIOS_A, 20'h0);
        expect_val("bios_do", S_DO, 20'h31);
        expect_val("bios_ram_ce", S_RAM_CE, 20'h1);
        bus_op(K_RD, 16'h0000, 8'h00);

        // 2000 unmapped with SGM off
        expect_val("unm_do", S_DO, 20'hFF);
        expect_val("unm_ram_ce", S_RAM_CE, 20'h1);
        expect_val("unm_up_ce", S_UP_CE, 20'h1);
        expect_val("unm_cart_rd", S_CART_RD, 20'h0);
        bus_op(K_RD, 16'h2000, 8'h00);

        // Enable SGM upper RAM and switch BIOS out
        bus_op(K_IO, 16'h0053, 8'h01);
        bus_op(K_IO, 16'h007F, 8'h00);

        expect_val("sgm_wr_we", S_UP_WE, 20'h0);
        expect_val("sgm_wr_ce", S_UP_CE, 20'h0);
        expect_val("sgm_wr_a", S_UP_A, 20'h0100);
        expect_val("sgm_wr_do", S_RAM_DO, 20'h99);
        bus_op(K_WR, 16'h0100, 8'h99);

        expect_val("sgm_rd_ce", S_UP_CE, 20'h0);
        expect_val("sgm_rd_we", S_UP_WE, 20'h1);
        expect_val("sgm_rd_a", S_UP_A, 20'h4000);
        expect_val("sgm_rd_do", S_DO, 20'hC3);
        bus_op(K_RD, 16'h4000, 8'h00);

        // Base RAM write
        expect_val("ram_wr_a", S_RAM_A, 20'h0005);
        expect_val("ram_wr_we", S_RAM_WE, 20'h0);
        expect_val("ram_wr_ce", S_RAM_CE, 20'h0);
        expect_val("ram_wr_do", S_RAM_DO, 20'hAA);
        expect_val("ram_wr_up_ce", S_UP_CE, 20'h1);
        expect_val("ram_wr_cart_rd", S_CART_RD, 20'h0);
        bus_op(K_WR, 16'h6005, 8'hAA);

        // Reset coincident with a bios_off write: reset wins
        reset = 1'b1;
        bus_op(K_IO, 16'h007F, 8'h00);
        reset = 1'b0;
        expect_val("rstw_bios_do", S_DO, 20'h31);
        expect_val("rstw_up_ce", S_UP_CE, 20'h1);
        bus_op(K_RD, 16'h0000, 8'h00);
        expect_val("rstw_sgm_off", S_DO, 20'hFF);
        bus_op(K_RD, 16'h4000, 8'h00);

        // MegaCart banking, 8 pages
        cart_pages_i = 6'd7;
        bus_op(K_RD, 16'hFFC3, 8'h00);
        expect_val("bank3_a", S_CART_A, 20'h0C010);
        expect_val("bank3_rd", S_CART_RD, 20'h1);
        expect_val("bank3_do", S_DO, 20'h7E);
        bus_op(K_RD, 16'hC010, 8'h00);
        expect_val("fixed_a", S_CART_A, 20'h1C000);
        bus_op(K_RD, 16'h8000, 8'h00);

        pulse_reset();
        expect_val("bank_rst_a", S_CART_A, 20'h00010);
        bus_op(K_RD, 16'hC010, 8'h00);

        // Bank select by write, then small cart must not change the bank
        bus_op(K_WR, 16'hFFC2, 8'h00);
        cart_pages_i = 6'd1;
        bus_op(K_RD, 16'hFFC5, 8'h00);
        expect_val("small_a", S_CART_A, 20'h04000);
        bus_op(K_RD, 16'hC000, 8'h00);
        cart_pages_i = 6'd7;
        expect_val("bank_kept_a", S_CART_A, 20'h08000);
        bus_op(K_RD, 16'hC000, 8'h00);

        // Out-of-range bank aliases through the page mask
        cart_pages_i = 6'd3;
        bus_op(K_RD, 16'hFFC7, 8'h00);
        expect_val("alias_a", S_CART_A, 20'h0C000);
        bus_op(K_RD, 16'hC000, 8'h00);
        expect_val("fixed4_a", S_CART_A, 20'h0C123);
        bus_op(K_RD, 16'h8123, 8'h00);

        // SG-1000 map
        sg1000_i = 1'b1;
        expect_val("sg_cart_a", S_CART_A, 20'h01234);
        expect_val("sg_cart_rd", S_CART_RD, 20'h1);
        bus_op(K_RD, 16'h1234, 8'h00);
        expect_val("sg_ram_a", S_RAM_A, 20'h0001);
        expect_val("sg_ram_we", S_RAM_WE, 20'h0);
        bus_op(K_WR, 16'hE001, 8'h55);
        expect_val("sg_mirror_a", S_RAM_A, 20'h0001);
        expect_val("sg_mirror_do", S_DO, 20'h5A);
        bus_op(K_RD, 16'hC001, 8'h00);
        expect_val("sg_nodj_a", S_CART_A, 20'h02001);
        expect_val("sg_nodj_up", S_UP_CE, 20'h1);
        bus_op(K_RD, 16'h2001, 8'h00);
        dahjeeA_i = 1'b1;
        expect_val("sg_dj_a", S_UP_A, 20'h0001);
        expect_val("sg_dj_ce", S_UP_CE, 20'h0);
        expect_val("sg_dj_do", S_DO, 20'hC3);
        expect_val("sg_dj_cart_rd", S_CART_RD, 20'h0);
        bus_op(K_RD, 16'h2001, 8'h00);
        expect_val("sg_hi_cart_a", S_CART_A, 20'h0BFFF);
        bus_op(K_RD, 16'hBFFF, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
